// File: rtl/npc_state_sequencer.sv
// npc_state_sequencer: registered 3-level NPC state decoder with dwell-limited one-level leg stepping and neutral parking.
// Optional STATE_RANGE_CHECK_EN adds a sticky state_err flag for out-of-range state strobes.
module npc_state_sequencer #(
  parameter int NUM_LEGS  = 3,
  parameter int STATE_W   = 5,
  parameter int MIN_DWELL = 4,
  parameter int DWELL_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  state_valid,
  input  logic [STATE_W-1:0]    state,
  input  logic                  enable,
  input  logic                  fault,
  input  logic                  fault_clr,
  output logic [2*NUM_LEGS-1:0] legs,
  output logic                  busy,
`ifdef STATE_RANGE_CHECK_EN
  output logic                  state_err,
`endif
  output logic                  fault_active
);
  localparam int NUM_STATES = 3**NUM_LEGS;
  localparam logic [STATE_W-1:0] MAX_STATE = STATE_W'(NUM_STATES);
  localparam logic [STATE_W-1:0] THREE = STATE_W'(3);
  localparam logic [1:0] LVL_N = 2'b00;
  localparam logic [1:0] LVL_Z = 2'b10;
  localparam logic [1:0] LVL_P = 2'b11;
  localparam logic [2*NUM_LEGS-1:0] ALL_Z = {NUM_LEGS{LVL_Z}};
  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(MIN_DWELL - 1);
  logic                              in_range;
  logic [STATE_W-1:0]                rem;
  logic [1:0]                        digit;
  logic [2*NUM_LEGS-1:0]             decoded, target, eff, next_legs;
  logic [NUM_LEGS-1:0][DWELL_W-1:0]  dwell, next_dwell;
  // Base-3 digits of state-1, leg 0 taking the least significant digit
  always_comb begin
    in_range = (state != '0) && (state <= MAX_STATE);
    rem = state - STATE_W'(1);
    digit = 2'd0;
    decoded = ALL_Z;
    for (int k = 0; k < NUM_LEGS; k++) begin
      digit = 2'(rem % THREE);
      decoded[2*k +: 2] = !in_range ? LVL_Z : digit == 2'd0 ? LVL_N : digit == 2'd1 ? LVL_Z : LVL_P;
      rem = rem / THREE;
    end
  end
  // From n or p the only legal step is to neutral; from neutral go straight to the target
  always_comb begin
    eff = (enable && !fault_active) ? target : ALL_Z;
    busy = legs != eff;
    next_legs = legs;
    next_dwell = dwell;
    for (int k = 0; k < NUM_LEGS; k++) begin
      if (legs[2*k +: 2] != eff[2*k +: 2] && dwell[k] == '0) begin
        next_legs[2*k +: 2] = legs[2*k +: 2] == LVL_Z ? eff[2*k +: 2] : LVL_Z;
        next_dwell[k] = DWELL_LOAD;
      end else if (dwell[k] != '0) begin
        next_dwell[k] = dwell[k] - DWELL_W'(1);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      legs <= ALL_Z;
      target <= ALL_Z;
      dwell <= '0;
      fault_active <= 1'b0;
    end else begin
      legs <= next_legs;
      dwell <= next_dwell;
      if (state_valid) target <= decoded;
      fault_active <= fault | (fault_active & ~fault_clr);
    end
  end
`ifdef STATE_RANGE_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_err <= 1'b0;
    else state_err <= (state_valid & ~in_range) | (state_err & ~fault_clr);
  end
`endif
endmodule

// File: tb/tb_npc_state_sequencer.sv
// tb_npc_state_sequencer: directed checks of decode, dwell stepping, parking, fault and reset behaviour.
module tb_npc_state_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       state_valid = 1'b0;
  logic [4:0] state = '0;
  logic       enable = 1'b1;
  logic       fault = 1'b0;
  logic       fault_clr = 1'b0;
  logic [5:0] legs;
  logic       busy, fault_active;
`ifdef STATE_RANGE_CHECK_EN
  logic       state_err;
`endif
  int checks = 0;
  int errors = 0;

  npc_state_sequencer dut (
    .clk(clk), .rst_n(rst_n), .state_valid(state_valid), .state(state),
    .enable(enable), .fault(fault), .fault_clr(fault_clr),
    .legs(legs), .busy(busy),
`ifdef STATE_RANGE_CHECK_EN
    .state_err(state_err),
`endif
    .fault_active(fault_active)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic expect_legs(input string tag, input logic [5:0] l, input logic b);
    check({tag, "_legs"}, {2'b00, legs}, {2'b00, l});
    check({tag, "_busy"}, {7'd0, busy}, {7'd0, b});
  endtask

  task automatic expect_fa(input string tag, input logic f);
    check({tag, "_fault_active"}, {7'd0, fault_active}, {7'd0, f});
  endtask

  task automatic strobe(input logic [4:0] s);
    state = s;
    state_valid = 1'b1;
    tick();
    state_valid = 1'b0;
  endtask

  initial begin
    tick(2);
    expect_legs("in_reset", 6'b101010, 1'b0);
    expect_fa("in_reset", 1'b0);
    rst_n = 1'b1;
    tick(10);
    expect_legs("idle", 6'b101010, 1'b0);
    expect_fa("idle", 1'b0);

    strobe(5'd1);
    expect_legs("s1_target", 6'b101010, 1'b1);
    tick();
    expect_legs("s1_step", 6'b000000, 1'b0);

    tick(4);
    strobe(5'd27);
    expect_legs("s27_target", 6'b000000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_legs($sformatf("s27_mid%0d", i), 6'b101010, 1'b1);
    end
    tick();
    expect_legs("s27_done", 6'b111111, 1'b0);

    tick(3);
    fault = 1'b1;
    fault_clr = 1'b1;
    tick();
    expect_fa("fault_set_wins", 1'b1);
    expect_legs("fault_set", 6'b111111, 1'b1);
    fault = 1'b0;
    fault_clr = 1'b0;
    tick();
    expect_fa("fault_sticky", 1'b1);
    expect_legs("fault_park", 6'b101010, 1'b0);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    expect_fa("fault_clr", 1'b0);
    expect_legs("fault_clr", 6'b101010, 1'b1);
    tick(2);
    expect_legs("fault_dwell", 6'b101010, 1'b1);
    tick();
    expect_legs("fault_resume", 6'b111111, 1'b0);

    strobe(5'd1);
    tick(12);
    expect_legs("back_n", 6'b000000, 1'b0);
    strobe(5'd3);
    expect_legs("s3_target", 6'b000000, 1'b1);
    strobe(5'd1);
    expect_legs("retarget_step", 6'b000010, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_legs($sformatf("retarget_dwell%0d", i), 6'b000010, 1'b1);
    end
    tick();
    expect_legs("retarget_done", 6'b000000, 1'b0);

    tick(4);
    strobe(5'd0);
    expect_legs("s0_target", 6'b000000, 1'b1);
    tick(8);
    expect_legs("s0_settle", 6'b101010, 1'b0);
`ifdef STATE_RANGE_CHECK_EN
    check("state_err_set", {7'd0, state_err}, 8'd1);
`endif
    strobe(5'd27);
    tick(10);
    expect_legs("s27_again", 6'b111111, 1'b0);
    enable = 1'b0;
    strobe(5'd1);
    tick(8);
    expect_legs("disabled_park", 6'b101010, 1'b0);
    enable = 1'b1;
    tick(8);
    expect_legs("enabled_apply", 6'b000000, 1'b0);
    strobe(5'd28);
    tick(8);
    expect_legs("s28_settle", 6'b101010, 1'b0);
`ifdef STATE_RANGE_CHECK_EN
    check("state_err_hold", {7'd0, state_err}, 8'd1);
    fault_clr = 1'b1;
    tick();
    fault_clr = 1'b0;
    check("state_err_clr", {7'd0, state_err}, 8'd0);
`endif

    strobe(5'd1);
    tick(8);
    expect_legs("pre_reset", 6'b000000, 1'b0);
    strobe(5'd27);
    expect_legs("pre_reset_target", 6'b000000, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    expect_legs("async_reset", 6'b101010, 1'b0);
    expect_fa("async_reset", 1'b0);
    rst_n = 1'b1;
    tick(6);
    expect_legs("after_reset", 6'b101010, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
